program_loader: RTL and testbench

- Writer side of the instruction memory: receives a program image over a UART serial line and writes it word-by-word into the 16x16-bit instruction store that the processor core reads.
- Holds the core stalled while a load is in progress and reports done or error status for the LEDs.
- Sits beside the core on the DE0-Nano top level; its serial input comes in on a GPIO pin.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/uart_rx.sv | 127 ++++++++++++
 rtl/program_loader.sv | 196 +++++++++++++++++++
 tb/tb_program_loader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: frame FSM and UART receiver
// state encodings, the sync byte, and default timing constants for a
// 50 MHz clock at 115200 baud.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        CHECK,
        ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE          = 8'hA5;
    localparam int         CLKS_PER_BIT_DEF   = 434;
    localparam int         TIMEOUT_CYCLES_DEF = 5000000;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first.
// Ports:
//   CLOCK_50   in   system clock
//   RESET_N    in   synchronous active-low reset
//   rxd        in   serial line, idle high, asynchronous to CLOCK_50
//   byte_valid out  one-cycle strobe, byte_data holds the received byte
//   byte_data  out  received byte
//   frame_err  out  one-cycle strobe when the stop bit was sampled low
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(CLKS_PER_BIT - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             prev_q, prev_d;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        meta_d       = rxd;
        sync_d       = meta_q;
        prev_d       = sync_q;
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        frame_err_d  = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                // Falling edge on the synchronised line marks a start bit.
                if (prev_q && !sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // Line back high at mid-start-bit: treat as a glitch.
                    rx_state_d = sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    if (sync_q) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            meta_q       <= 1'b1;
            sync_q       <= 1'b1;
            prev_q       <= 1'b1;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            meta_q       <= meta_d;
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/program_loader.sv
// Loads a program image received over UART into the instruction memory.
// Frame: A5, N, N x {hi, lo}, CK where CK = XOR of N and all data bytes.
// Ports:
//   CLOCK_50   in   system clock
//   RESET_N    in   synchronous active-low reset
//   UART_RXD   in   serial input (8N1, idle high)
//   mem_we     out  one-cycle instruction memory write strobe
//   mem_addr   out  write address
//   mem_wdata  out  write data
//   cpu_hold   out  core must not run while high
//   load_done  out  sticky: last frame loaded successfully
//   load_err   out  sticky: last frame failed
module program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEF,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              UART_RXD,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .rxd       (UART_RXD),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    loader_state_t     state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;

    logic timed_out;
    logic in_frame;

    assign timed_out = (tmo_q == TMO_W'(TIMEOUT_CYCLES));
    assign in_frame  = (state_q == COUNT) || (state_q == HI) ||
                       (state_q == LO) || (state_q == CHECK);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        hi_d        = hi_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;

        // Inter-byte timer only runs while a frame is open.
        if (!in_frame || byte_valid) begin
            tmo_d = '0;
        end else if (!timed_out) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = tmo_q;
        end

        case (state_q)
            IDLE: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    cpu_hold_d  = 1'b1;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    state_d     = COUNT;
                end
            end
            COUNT: begin
                if (byte_valid) begin
                    if (byte_data == 8'd0 || int'(byte_data) > DEPTH) begin
                        state_d = ERR;
                    end else begin
                        count_d = byte_data[ADDR_W:0];
                        idx_d   = '0;
                        csum_d  = byte_data;
                        state_d = HI;
                    end
                end
            end
            HI: begin
                if (byte_valid) begin
                    hi_d    = byte_data;
                    csum_d  = csum_q ^ byte_data;
                    state_d = LO;
                end
            end
            LO: begin
                if (byte_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = idx_q;
                    mem_wdata_d = {hi_q, byte_data};
                    csum_d      = csum_q ^ byte_data;
                    if ({1'b0, idx_q} == count_q - 1'b1) begin
                        state_d = CHECK;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = HI;
                    end
                end
            end
            CHECK: begin
                if (byte_valid) begin
                    if (byte_data == csum_q) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                // cpu_hold is left high so a partial image never runs.
                load_err_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Line errors and silence abort any open frame.
        if (in_frame && (frame_err || timed_out)) begin
            state_d  = ERR;
            mem_we_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            hi_q        <= '0;
            csum_q      <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            hi_q        <= hi_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a shortened bit time and timeout.
module tb_program_loader;

    localparam int CPB     = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 1000;

    logic              clk;
    logic              rst_n;
    logic              rxd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    int tests_run;
    int tests_failed;

    // Write capture
    int                wr_total;
    logic [ADDR_W-1:0] wr_addr [0:255];
    logic [15:0]       wr_data [0:255];

    program_loader #(
        .CLKS_PER_BIT  (CPB),
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .UART_RXD (rxd),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .load_done(load_done),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr[wr_total[7:0]] <= mem_addr;
            wr_data[wr_total[7:0]] <= mem_wdata;
            wr_total               <= wr_total + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_good();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'hD0, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hC2, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err} !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%h want=0",
                     {mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        int base;
        base = wr_total;
        send_good();
        tests_run++;
        if (wr_total - base !== 2) begin
            tests_failed++;
            $display("FAIL good_writes got=%0d want=2", wr_total - base);
        end
        tests_run++;
        if ({wr_addr[base], wr_data[base]} !== {4'd0, 16'h0110}) begin
            tests_failed++;
            $display("FAIL good_word0 got=%h/%h want=0/0110", wr_addr[base], wr_data[base]);
        end
        tests_run++;
        if ({wr_addr[base+1], wr_data[base+1]} !== {4'd1, 16'hD001}) begin
            tests_failed++;
            $display("FAIL good_word1 got=%h/%h want=1/d001", wr_addr[base+1], wr_data[base+1]);
        end
        tests_run++;
        if ({cpu_hold, load_done, load_err} !== 3'b010) begin
            tests_failed++;
            $display("FAIL good_status got=%b want=010", {cpu_hold, load_done, load_err});
        end
    endtask

    task automatic test_bad_checksum();
        int base;
        base = wr_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'hD0, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hC3, 1'b1);
        tests_run++;
        if (wr_total - base !== 2) begin
            tests_failed++;
            $display("FAIL badck_writes got=%0d want=2", wr_total - base);
        end
        tests_run++;
        if ({cpu_hold, load_done, load_err} !== 3'b101) begin
            tests_failed++;
            $display("FAIL badck_status got=%b want=101", {cpu_hold, load_done, load_err});
        end
        send_good();
        tests_run++;
        if ({cpu_hold, load_done, load_err} !== 3'b010) begin
            tests_failed++;
            $display("FAIL badck_recover got=%b want=010", {cpu_hold, load_done, load_err});
        end
    endtask

    task automatic test_noise();
        int base;
        base = wr_total;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        tests_run++;
        if ({wr_total - base, cpu_hold, load_done, load_err} !== {32'd0, 3'b010}) begin
            tests_failed++;
            $display("FAIL noise_ignored got=%0d/%b want=0/010",
                     wr_total - base, {cpu_hold, load_done, load_err});
        end
        send_good();
        tests_run++;
        if ({wr_total - base, wr_addr[base], cpu_hold, load_done, load_err}
            !== {32'd2, 4'd0, 3'b010}) begin
            tests_failed++;
            $display("FAIL noise_load got=%0d/%h/%b want=2/0/010",
                     wr_total - base, wr_addr[base], {cpu_hold, load_done, load_err});
        end
    endtask

    task automatic test_count_bounds();
        int base;
        base = wr_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        tests_run++;
        if ({wr_total - base, cpu_hold, load_done, load_err} !== {32'd0, 3'b101}) begin
            tests_failed++;
            $display("FAIL count_zero got=%0d/%b want=0/101",
                     wr_total - base, {cpu_hold, load_done, load_err});
        end
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        tests_run++;
        if ({wr_total - base, cpu_hold, load_done, load_err} !== {32'd0, 3'b101}) begin
            tests_failed++;
            $display("FAIL count_17 got=%0d/%b want=0/101",
                     wr_total - base, {cpu_hold, load_done, load_err});
        end
        // Words {i, 80+i}: data bytes XOR to 0, so CK equals N = 0x10.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 1'b1);
            send_byte(8'(8'h80 + i), 1'b1);
        end
        send_byte(8'h10, 1'b1);
        tests_run++;
        if (wr_total - base !== 16) begin
            tests_failed++;
            $display("FAIL count_16_writes got=%0d want=16", wr_total - base);
        end
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if ({wr_addr[base+i], wr_data[base+i]} !== {4'(i), 8'(i), 8'(8'h80 + i)}) begin
                tests_failed++;
                $display("FAIL count_16_word%0d got=%h/%h want=%h/%h", i,
                         wr_addr[base+i], wr_data[base+i], 4'(i), {8'(i), 8'(8'h80 + i)});
            end
        end
        tests_run++;
        if ({cpu_hold, load_done, load_err} !== 3'b010) begin
            tests_failed++;
            $display("FAIL count_16_status got=%b want=010", {cpu_hold, load_done, load_err});
        end
    endtask

    task automatic test_framing();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h10, 1'b0);
        tests_run++;
        if ({cpu_hold, load_done, load_err} !== 3'b101) begin
            tests_failed++;
            $display("FAIL framing_status got=%b want=101", {cpu_hold, load_done, load_err});
        end
    endtask

    task automatic test_timeout();
        int base;
        send_good();
        base = wr_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        tests_run++;
        if ({cpu_hold, load_err} !== 2'b10) begin
            tests_failed++;
            $display("FAIL timeout_early got=%b want=10", {cpu_hold, load_err});
        end
        repeat (TIMEOUT + 100) @(negedge clk);
        tests_run++;
        if ({wr_total - base, cpu_hold, load_done, load_err} !== {32'd0, 3'b101}) begin
            tests_failed++;
            $display("FAIL timeout_status got=%0d/%b want=0/101",
                     wr_total - base, {cpu_hold, load_done, load_err});
        end
    endtask

    task automatic test_reset_mid();
        int base;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err} !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs got=%h want=0",
                     {mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        base = wr_total;
        send_good();
        tests_run++;
        if ({wr_total - base, wr_data[base], cpu_hold, load_done, load_err}
            !== {32'd2, 16'h0110, 3'b010}) begin
            tests_failed++;
            $display("FAIL reset_mid_reload got=%0d/%h/%b want=2/0110/010",
                     wr_total - base, wr_data[base], {cpu_hold, load_done, load_err});
        end
    endtask

    task automatic test_glitch();
        int base;
        base = wr_total;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        // Short low pulse, well under half a bit: must not become a byte.
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB / 2 - 3) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h01, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'hD0, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hC2, 1'b1);
        tests_run++;
        if ({wr_total - base, wr_data[base+1], cpu_hold, load_done, load_err}
            !== {32'd2, 16'hD001, 3'b010}) begin
            tests_failed++;
            $display("FAIL glitch_load got=%0d/%h/%b want=2/d001/010",
                     wr_total - base, wr_data[base+1], {cpu_hold, load_done, load_err});
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        wr_total     = 0;
        rxd          = 1'b1;
        rst_n        = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_noise();
        test_count_bounds();
        test_framing();
        test_timeout();
        test_reset_mid();
        test_glitch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
